fifo_ext: RTL and testbench
===========================

FIFO_EXT -- requirements
Module: fifo_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, giving depth DEPTH = 2**ADDR_WIDTH (ADDR_WIDTH >= 1).
REQ-003 SHALL have parameter REG_OUT, default 0: 0 = head word driven combinationally, 1 = registered read data.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-005 SHALL have parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH-1).
REQ-006 SHALL use one clock and an asynchronous, active-high reset:
  i_clk  input  1  clock, all state on rising edge
  i_reset  input  1  asynchronous active-high reset
  i_wr  input  1  write request
  i_w_data  input  DATA_WIDTH  write data
  i_rd  input  1  read (pop) request
  o_r_data  output  DATA_WIDTH  read data
  o_r_valid  output  1  o_r_data valid (REG_OUT=1 only; tied to ~o_empty when REG_OUT=0)
  o_empty  output  1  count == 0
  o_full  output  1  count == DEPTH
  o_almost_empty  output  1  count <= AE_LEVEL
  o_almost_full  output  1  count >= AF_LEVEL
  o_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
  o_overflow  output  1  one-cycle pulse: write dropped
  o_underflow  output  1  one-cycle pulse: read ignored

Function
REQ-007 Write accepted SHALL be i_wr & (~o_full | i_rd); accepted word stored at write pointer, pointer +1 mod DEPTH.
REQ-008 Read accepted SHALL be i_rd & ~o_empty; read pointer +1 mod DEPTH.
REQ-009 Full with i_rd & i_wr: both accepted, count unchanged, o_full stays 1, no overflow.
REQ-010 Empty with i_rd & i_wr: write accepted, read ignored, o_underflow pulses, count becomes 1 (no pass-through).
REQ-011 i_wr while full without i_rd: data discarded, state unchanged, o_overflow = 1 for the next cycle only.
REQ-012 i_rd while empty: state unchanged, o_underflow = 1 for the next cycle only.
REQ-013 o_count SHALL update on the same edge as pointers: +1 write-only, -1 read-only, unchanged otherwise; all flags derived combinationally from registered count.
REQ-014 REG_OUT=0: o_r_data = word at read pointer, zero latency; value undefined-but-stable when empty.
REQ-015 REG_OUT=1: on accepted read, o_r_data/o_r_valid load popped word/1 at that edge (latency 1); o_r_valid = 0 after any edge without accepted read; o_r_data holds last value.
REQ-016 Pointers SHALL wrap from DEPTH-1 to 0 with no gap; full/empty distinguished by count, not pointer equality.

Reset
REQ-017 i_reset assertion SHALL immediately clear pointers, o_count, o_overflow, o_underflow, o_r_valid, and o_r_data (REG_OUT=1) to 0; o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=(AF_LEVEL==0 ? 1 : 0).
REQ-018 Reset mid-operation SHALL discard all contents; storage array not cleared; first post-reset read returns first post-reset write.

Structure
REQ-019 Package fifo_pkg SHALL hold the REG_OUT mode constants and count-width helper; parameter range checks SHALL be elaboration-time assertions.
REQ-020 Storage SHALL be one sub-module, reg_file (DATA_WIDTH, ADDR_WIDTH, write-enable = accepted write, async read); control/flags in fifo_ext.

Verification
REQ-021 DATA_WIDTH=8, ADDR_WIDTH=2: write 0x11,0x22,0x33,0x44 -> o_full=1, o_count=4; 5th write 0x55 -> o_overflow one cycle, reads return 0x11..0x44, 0x55 absent.
REQ-022 Empty, pulse i_rd -> o_underflow one cycle, o_count=0, pointers unchanged.
REQ-023 Full, i_rd&i_wr with 0xA5 for 8 cycles -> o_count stays 4, outputs in write order through wrap-around, no flag pulses.
REQ-024 AF_LEVEL=3, AE_LEVEL=1: fill 0->4 -> o_almost_empty deasserts at count 2, o_almost_full asserts at count 3.
REQ-025 REG_OUT=1: write 0x7E, read -> o_r_data=0x7E with o_r_valid=1 exactly one cycle after read edge.
REQ-026 Write 3 words, assert i_reset asynchronously mid-cycle -> outputs at reset values before next edge; write 0x99, read -> 0x99.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_ext block.
// No logic; elaboration-time only.
// No flow control.
package fifo_pkg;

  // Read-data presentation modes selected by the REG_OUT parameter.
  localparam int REG_OUT_COMB = 0;
  localparam int REG_OUT_REG  = 1;

  // Occupancy counter must hold 0..2**addr_width inclusive.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read is combinational from the address.
// No flow control; the caller gates the write enable.
module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the word on an enabled write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_ext.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds and overflow/underflow pulses.
// Read data is zero latency (REG_OUT=0) or registered one cycle after the pop (REG_OUT=1).
// Writes into a full FIFO are dropped unless a pop happens the same cycle; pops from empty are ignored.
module fifo_ext
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int REG_OUT    = REG_OUT_COMB,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_wr,
  input  logic [DATA_WIDTH-1:0]   i_w_data,
  input  logic                    i_rd,
  output logic [DATA_WIDTH-1:0]   o_r_data,
  output logic                    o_r_valid,
  output logic                    o_empty,
  output logic                    o_full,
  output logic                    o_almost_empty,
  output logic                    o_almost_full,
  output logic [ADDR_WIDTH:0]     o_count,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = count_width(ADDR_WIDTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  // Parameter sanity checks, evaluated at elaboration.
  if (ADDR_WIDTH < 1) begin : g_chk_aw
    $error("fifo_ext: ADDR_WIDTH must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_chk_dw
    $error("fifo_ext: DATA_WIDTH must be >= 1");
  end
  if (REG_OUT != REG_OUT_COMB && REG_OUT != REG_OUT_REG) begin : g_chk_ro
    $error("fifo_ext: REG_OUT must be 0 or 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
    $error("fifo_ext: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
    $error("fifo_ext: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  overflow;
  logic                  underflow;
  logic [DATA_WIDTH-1:0] rf_rdata;

  // Flags come straight from the registered count, so full/empty never rely on pointer equality.
  assign o_empty        = (count == '0);
  assign o_full         = (count == DEPTH_C);
  assign o_almost_empty = (count <= AE_C);
  assign o_almost_full  = (count >= AF_C);
  assign o_count        = count;
  assign o_overflow     = overflow;
  assign o_underflow    = underflow;

  // A full FIFO still takes a write when a pop frees the head slot on the same edge.
  assign wr_ok = i_wr & (~o_full | i_rd);
  // Empty FIFO never passes a same-cycle write through to the read side.
  assign rd_ok = i_rd & ~o_empty;

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_reg_file (
    .clk    (i_clk),
    .we     (wr_ok),
    .w_addr (wr_ptr),
    .w_data (i_w_data),
    .r_addr (rd_ptr),
    .r_data (rf_rdata)
  );

  // Occupancy follows accepted operations: +1 write only, -1 read only, otherwise hold.
  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers, count and the one-cycle error pulses; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count     <= count_nxt;
      overflow  <= i_wr & ~wr_ok;
      underflow <= i_rd & ~rd_ok;
    end
  end

  if (REG_OUT == REG_OUT_REG) begin : g_reg_out
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;

    // Capture the popped head word; valid marks only the cycle right after an accepted read.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_ok;
        if (rd_ok) begin
          r_data_q <= rf_rdata;
        end
      end
    end

    assign o_r_data  = r_data_q;
    assign o_r_valid = r_valid_q;
  end else begin : g_comb_out
    assign o_r_data  = rf_rdata;
    assign o_r_valid = ~o_empty;
  end

endmodule

// File: tb/tb_fifo_ext.sv
// Directed bench for fifo_ext: combinational-output instance (a_*) and registered-output instance (b_*).
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
// Expected values are hand-derived constants.
module tb_fifo_ext;

  logic       clk;
  logic       rst;

  logic       a_wr, a_rd;
  logic [7:0] a_wdata;
  logic [7:0] a_rdata;
  logic       a_valid, a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic [2:0] a_count;

  logic       b_wr, b_rd;
  logic [7:0] b_wdata;
  logic [7:0] b_rdata;
  logic       b_valid, b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
  logic [2:0] b_count;

  int n_chk;
  int n_fail;

  fifo_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .REG_OUT(0), .AF_LEVEL(3), .AE_LEVEL(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_wr(a_wr), .i_w_data(a_wdata), .i_rd(a_rd),
    .o_r_data(a_rdata), .o_r_valid(a_valid), .o_empty(a_empty), .o_full(a_full),
    .o_almost_empty(a_ae), .o_almost_full(a_af), .o_count(a_count),
    .o_overflow(a_ovf), .o_underflow(a_udf)
  );

  fifo_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .REG_OUT(1), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_wr(b_wr), .i_w_data(b_wdata), .i_rd(b_rd),
    .o_r_data(b_rdata), .o_r_valid(b_valid), .o_empty(b_empty), .o_full(b_full),
    .o_almost_empty(b_ae), .o_almost_full(b_af), .o_count(b_count),
    .o_overflow(b_ovf), .o_underflow(b_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q [4];
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    a_wr = 1'b0; a_rd = 1'b0; a_wdata = 8'h00;
    b_wr = 1'b0; b_rd = 1'b0; b_wdata = 8'h00;
    #2;
    // Reset state
    chk("rst_a_count", a_count, 0);
    chk("rst_a_empty", a_empty, 1);
    chk("rst_a_full", a_full, 0);
    chk("rst_a_ae", a_ae, 1);
    chk("rst_a_af", a_af, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_udf", a_udf, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_ae", b_ae, 1);
    chk("rst_b_af", b_af, 0);
    rst = 1'b0;
    cyc();

    // Fill 0 -> 4, tracking thresholds (AE=1, AF=3)
    a_wr = 1'b1; a_wdata = 8'h11; cyc();
    chk("fill1_count", a_count, 1);
    chk("fill1_ae", a_ae, 1);
    chk("fill1_head", a_rdata, 8'h11);
    chk("fill1_valid", a_valid, 1);
    a_wdata = 8'h22; cyc();
    chk("fill2_count", a_count, 2);
    chk("fill2_ae", a_ae, 0);
    chk("fill2_af", a_af, 0);
    a_wdata = 8'h33; cyc();
    chk("fill3_count", a_count, 3);
    chk("fill3_af", a_af, 1);
    chk("fill3_full", a_full, 0);
    a_wdata = 8'h44; cyc();
    chk("fill4_count", a_count, 4);
    chk("fill4_full", a_full, 1);
    chk("fill4_ovf", a_ovf, 0);
    // Fifth write is dropped
    a_wdata = 8'h55; cyc();
    a_wr = 1'b0;
    chk("ovf_pulse", a_ovf, 1);
    chk("ovf_count", a_count, 4);
    chk("ovf_head", a_rdata, 8'h11);
    cyc();
    chk("ovf_clear", a_ovf, 0);

    // Drain in order; 0x55 must not appear
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_data", i), a_rdata, exp_q[i]);
      a_rd = 1'b1;
      cyc();
    end
    a_rd = 1'b0;
    chk("drain_count", a_count, 0);
    chk("drain_empty", a_empty, 1);
    chk("drain_udf", a_udf, 0);

    // Pop from empty
    a_rd = 1'b1; cyc(); a_rd = 1'b0;
    chk("udf_pulse", a_udf, 1);
    chk("udf_count", a_count, 0);
    cyc();
    chk("udf_clear", a_udf, 0);

    // Read+write on empty: write lands, read ignored
    a_wr = 1'b1; a_rd = 1'b1; a_wdata = 8'h77; cyc();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("empty_rw_udf", a_udf, 1);
    chk("empty_rw_ovf", a_ovf, 0);
    chk("empty_rw_count", a_count, 1);
    chk("empty_rw_head", a_rdata, 8'h77);
    a_rd = 1'b1; cyc(); a_rd = 1'b0;
    chk("empty_rw_drain", a_count, 0);

    // Full with simultaneous read+write, through pointer wrap
    for (int i = 0; i < 4; i++) begin
      a_wr = 1'b1; a_wdata = 8'(i + 1); cyc();
    end
    chk("full_rw_start", a_full, 1);
    a_rd = 1'b1; a_wdata = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full_rw%0d_data", i), a_rdata, (i < 4) ? 32'(i + 1) : 32'hA5);
      cyc();
      chk($sformatf("full_rw%0d_count", i), a_count, 4);
      chk($sformatf("full_rw%0d_flags", i), {a_full, a_ovf, a_udf}, 3'b100);
    end
    a_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_rw_tail%0d", i), a_rdata, 8'hA5);
      cyc();
    end
    a_rd = 1'b0;
    chk("full_rw_end", a_count, 0);

    // Registered output instance
    b_wr = 1'b1; b_wdata = 8'h7E; cyc(); b_wr = 1'b0;
    chk("b_wr_valid", b_valid, 0);
    chk("b_wr_count", b_count, 1);
    b_rd = 1'b1; cyc(); b_rd = 1'b0;
    chk("b_rd_data", b_rdata, 8'h7E);
    chk("b_rd_valid", b_valid, 1);
    chk("b_rd_count", b_count, 0);
    cyc();
    chk("b_idle_valid", b_valid, 0);
    chk("b_idle_hold", b_rdata, 8'h7E);
    b_rd = 1'b1; cyc(); b_rd = 1'b0;
    chk("b_udf_valid", b_valid, 0);
    chk("b_udf_pulse", b_udf, 1);
    chk("b_udf_hold", b_rdata, 8'h7E);
    b_wr = 1'b1; b_wdata = 8'h12; cyc();
    b_wdata = 8'h34; cyc(); b_wr = 1'b0;
    b_rd = 1'b1; cyc();
    chk("b_b2b0_data", b_rdata, 8'h12);
    chk("b_b2b0_valid", b_valid, 1);
    cyc(); b_rd = 1'b0;
    chk("b_b2b1_data", b_rdata, 8'h34);
    chk("b_b2b1_valid", b_valid, 1);
    cyc();
    chk("b_b2b_end", b_valid, 0);

    // Asynchronous reset mid-cycle while full and with an overflow pulse pending
    a_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_wdata = 8'(8'h31 + i); cyc();
    end
    cyc();
    a_wr = 1'b0;
    chk("pre_rst_ovf", a_ovf, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", a_count, 0);
    chk("arst_empty", a_empty, 1);
    chk("arst_full", a_full, 0);
    chk("arst_ae_af", {a_ae, a_af}, 2'b10);
    chk("arst_ovf", a_ovf, 0);
    chk("arst_b_rdata", b_rdata, 0);
    #1 rst = 1'b0;
    cyc();
    a_wr = 1'b1; a_wdata = 8'h99; cyc(); a_wr = 1'b0;
    chk("post_rst_count", a_count, 1);
    chk("post_rst_data", a_rdata, 8'h99);
    a_rd = 1'b1; cyc(); a_rd = 1'b0;
    chk("post_rst_drain", a_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
